icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
- REQ-001: No parameters. Geometry is fixed by cpu_types_pkg: ITAG_W=26, IIDX_W=4 (16 entries), IBLK_W=0 (one word per block), IBYT_W=2. Addresses decompose as icachef_t.
- REQ-002: CLK  input  1  sole clock; all state updates on the rising edge.
- REQ-003: nRST  input  1  reset; asynchronous, active-low.
- REQ-004: imemREN  input  1  datapath instruction read request.
- REQ-005: imemaddr  input  32 (word_t)  datapath fetch address.
- REQ-006: ihit  output  1  requested word is valid on imemload this cycle.
- REQ-007: imemload  output  32 (word_t)  instruction to datapath.
- REQ-008: iREN  output  1  memory read request to the memory controller.
- REQ-009: iaddr  output  32 (word_t)  memory read address.
- REQ-010: iwait  input  1  memory busy; low means iload is valid this cycle.
- REQ-011: iload  input  32 (word_t)  memory read data.
- REQ-012: flush  input  1  invalidate all entries.

Function
- REQ-013: The cache is direct-mapped with 16 entries. Each entry holds valid, a 26-bit tag and a 32-bit word. Byte offset bits are ignored.
- REQ-014: Hit condition: imemREN && valid[idx] && tag[idx]==imemaddr.tag && state==IDLE.
  - ihit is combinational, in the same cycle.
  - imemload = data[idx].
- REQ-015: imemload is unconstrained when ihit=0. iREN=0 and iaddr=0 in IDLE.
- REQ-016: FSM has two states, IDLE and FETCH.
  - IDLE->FETCH on a miss (imemREN && !hit). This edge latches the miss address into missaddr, with bytoff forced to 2'b00.
- REQ-017: In FETCH:
  - iREN=1, iaddr=missaddr, ihit=0.
  - On a cycle with iwait=0, the entry at missaddr.idx is written (valid=1, tag, data=iload) and the FSM returns to IDLE.
- REQ-018: Miss latency: ihit asserts on the first IDLE cycle after the fill, provided imemaddr is unchanged. Total latency is memory latency + 1 cycle. There is no critical-word forwarding.
- REQ-019: FETCH is not abandoned if imemREN drops or imemaddr changes mid-fetch. The fill completes to missaddr.
- REQ-020: Flush:
  - When flush=1 in IDLE, all valid bits clear at the next edge, and ihit=0 that cycle.
  - When flush=1 in FETCH, valid bits clear. A fill completing in the same cycle is discarded (flush wins), and the FSM still returns to IDLE.
- REQ-021: A fill to an occupied index overwrites it; there is no replacement choice.

Reset
- REQ-022: While nRST=0:
  - state=IDLE, all valid bits=0, missaddr=0.
  - ihit=0, iREN=0, iaddr=0.
  - Tag and data arrays need not be cleared.
- REQ-023: Reset asserted mid-FETCH aborts the fetch immediately. iREN drops asynchronously.

Configuration
- REQ-024: When ICACHE_STATS_EN is defined, two 32-bit outputs are added.
  - hit_count: increments on each cycle with ihit=1.
  - miss_count: increments on each IDLE->FETCH transition.
  - Both reset to 0, wrap at 2^32-1 -> 0, and are not cleared by flush.
- REQ-025: When ICACHE_STATS_EN is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Verification
- REQ-026: Cold miss: after reset, imemREN=1, imemaddr=0x00000040; memory returns 0x8C010004 after 3 iwait cycles. Required: iREN=1 with iaddr=0x00000040 for 4 cycles, then ihit=1 and imemload=0x8C010004 on the next cycle.
- REQ-027: Hit: repeat 0x00000040. Required: ihit=1 the same cycle and iREN=0.
- REQ-028: Conflict: fetch 0x00000440 (same idx 0, different tag) after 0x00000040. Required: miss and refill. A re-fetch of 0x00000040 then misses again.
- REQ-029: Flush during FETCH, coincident with iwait=0. Required: FSM returns to IDLE, entry is invalid, and the next access to the same address misses.
- REQ-030: Address change mid-FETCH from 0x10 to 0x20. Required: iaddr stays 0x10, entry 4 is filled, and 0x20 then misses.
- REQ-031: With ICACHE_STATS_EN, after the scenarios above: hit_count and miss_count match the scoreboard exactly. Force miss_count to 0xFFFFFFFF and miss once; required: miss_count reads 0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped 16-entry instruction cache, one word per block, blocking miss FSM.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
package cpu_types_pkg;
    parameter int WORD_W = 32;
    parameter int ITAG_W = 26;
    parameter int IIDX_W = 4;
    parameter int IBYT_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;
endpackage

module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned NSETS = 1 << IIDX_W;

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e             state_q, state_d;
    logic [NSETS-1:0]   valid_q, valid_d;
    icachef_t           missaddr_q, missaddr_d;
    logic [ITAG_W-1:0]  tag_q  [NSETS];
    word_t              data_q [NSETS];

    icachef_t           req;
    logic               lookup_hit;
    logic               miss;
    logic               fill;
    logic               unused_bytoff;

    assign req           = icachef_t'(imemaddr);
    assign unused_bytoff = ^req.bytoff;

    // A flush in IDLE suppresses the hit in the same cycle it invalidates the array.
    always_comb begin
        lookup_hit = imemREN && (state_q == IDLE) && !flush &&
                     valid_q[req.idx] && (tag_q[req.idx] == req.tag);
        miss       = (state_q == IDLE) && imemREN && !lookup_hit;
        fill       = (state_q == FETCH) && !iwait;
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss)   state_d = FETCH;
            FETCH:   if (!iwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ihit     = lookup_hit;
        imemload = data_q[req.idx];
        iREN     = (state_q == FETCH);
        iaddr    = (state_q == FETCH) ? word_t'(missaddr_q) : '0;
    end

    always_comb begin
        valid_d    = valid_q;
        missaddr_d = missaddr_q;
        if (flush) begin
            valid_d = '0;
        end else if (fill) begin
            valid_d[missaddr_q.idx] = 1'b1;
        end
        if (miss) begin
            missaddr_d        = req;
            missaddr_d.bytoff = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q    <= '0;
            missaddr_q <= '0;
        end else begin
            valid_q    <= valid_d;
            missaddr_q <= missaddr_d;
        end
    end

    // Tag/data are qualified by valid, so a fill discarded by flush may still land here.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[missaddr_q.idx]  <= missaddr_q.tag;
            data_q[missaddr_q.idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, lookup_hit};
        miss_count_d = miss_count_q + {31'd0, miss};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
